// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - machine-mode CSR addresses, operation encoding and bit positions
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = (32'h1 << MIE_MTIE) | (32'h1 << MIE_MEIE);

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: csr_apply = wdata;
            CSR_OP_SET:   csr_apply = old | wdata;
            CSR_OP_CLEAR: csr_apply = old & ~wdata;
            default:      csr_apply = old;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - execute-stage / controller bundle into the CSR file
interface csr_file_if #(
    parameter int XLEN = 32
);
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      csr_op;
    logic            csr_rd;
    logic            csr_wr;
    logic [XLEN-1:0] pc;
    logic            trap;
    logic [XLEN-1:0] trap_cause;
    logic            mret;
    logic            timer_irq;
    logic            ext_irq;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] epc;
    logic            irq_req;
    logic            illegal;

    modport master (
        output addr, wdata, csr_op, csr_rd, csr_wr, pc, trap, trap_cause, mret,
               timer_irq, ext_irq,
        input  rdata, epc, irq_req, illegal
    );

    modport slave (
        input  addr, wdata, csr_op, csr_rd, csr_wr, pc, trap, trap_cause, mret,
               timer_irq, ext_irq,
        output rdata, epc, irq_req, illegal
    );
endinterface

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - 64-bit free-running cycle counter with per-half load
module csr_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc_en,
    input  logic        i_load_lo,
    input  logic        i_load_hi,
    input  logic [31:0] i_load_val,
    output logic [63:0] o_count
);
    logic [63:0] r_count;

    // A load of either half freezes the whole counter for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load_lo || i_load_hi) begin
            if (i_load_lo) r_count[31:0]  <= i_load_val;
            if (i_load_hi) r_count[63:32] <= i_load_val;
        end else if (i_inc_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap/mret sequencing and cycle counter
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic       clk,
    input  logic       rst,
    csr_file_if.slave  bus
);
    logic            r_st_mie;
    logic            r_st_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic            r_mtip;
    logic            r_meip;

    logic [63:0]     w_mcycle;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic [XLEN-1:0] w_tvec_base;
    logic            w_mapped;
    logic            w_wr_go;
    logic            w_ld_lo;
    logic            w_ld_hi;

    assign w_mstatus = MSTATUS_RESET | (XLEN'(r_st_mie) << MSTATUS_MIE)
                                     | (XLEN'(r_st_mpie) << MSTATUS_MPIE);
    assign w_mip     = (XLEN'(r_mtip) << MIP_MTIP) | (XLEN'(r_meip) << MIP_MEIP);

    always_comb begin
        w_mapped = 1'b1;
        w_old    = '0;
        case (bus.addr)
            CSR_MSTATUS:  w_old = w_mstatus;
            CSR_MIE:      w_old = r_mie;
            CSR_MTVEC:    w_old = r_mtvec;
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MEPC:     w_old = r_mepc;
            CSR_MCAUSE:   w_old = r_mcause;
            CSR_MIP:      w_old = w_mip;
            CSR_MCYCLE:   w_old = w_mcycle[31:0];
            CSR_MCYCLEH:  w_old = w_mcycle[63:32];
            default:      w_mapped = 1'b0;
        endcase
    end

    assign w_new = csr_apply(csr_op_e'(bus.csr_op), w_old, bus.wdata);

    // trap and mret each take the whole cycle; a concurrent CSR write is lost.
    assign w_wr_go = bus.csr_wr & w_mapped & ~bus.trap & ~bus.mret
                   & (csr_op_e'(bus.csr_op) != CSR_OP_NONE);
    assign w_ld_lo = w_wr_go & (bus.addr == CSR_MCYCLE);
    assign w_ld_hi = w_wr_go & (bus.addr == CSR_MCYCLEH);

    assign bus.rdata   = bus.csr_rd ? w_old : '0;
    assign bus.illegal = (bus.csr_rd | bus.csr_wr) & ~w_mapped;
    assign bus.irq_req = r_st_mie & (|(w_mip & r_mie));

    assign w_tvec_base = r_mtvec & ~XLEN'(3);

    always_comb begin
        bus.epc = r_mepc;
        if (bus.trap) begin
            if (r_mtvec[0] && bus.trap_cause[XLEN-1])
                bus.epc = w_tvec_base + (bus.trap_cause << 2);
            else
                bus.epc = w_tvec_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtip     <= 1'b0;
            r_meip     <= 1'b0;
        end else begin
            r_mtip <= bus.timer_irq;
            r_meip <= bus.ext_irq;
            if (bus.trap) begin
                r_mepc    <= bus.pc & ~XLEN'(3);
                r_mcause  <= bus.trap_cause;
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
            end else if (bus.mret) begin
                r_st_mie  <= r_st_mpie;
                r_st_mpie <= 1'b1;
            end else if (w_wr_go) begin
                case (bus.addr)
                    CSR_MSTATUS: begin
                        r_st_mie  <= w_new[MSTATUS_MIE];
                        r_st_mpie <= w_new[MSTATUS_MPIE];
                    end
                    CSR_MIE:      r_mie      <= w_new & MIE_WMASK;
                    CSR_MTVEC:    r_mtvec    <= w_new & ~XLEN'(2);
                    CSR_MSCRATCH: r_mscratch <= w_new;
                    CSR_MEPC:     r_mepc     <= w_new & ~XLEN'(3);
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    default: ;
                endcase
            end
        end
    end

    csr_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_inc_en   (~(w_ld_lo | w_ld_hi)),
        .i_load_lo  (w_ld_lo),
        .i_load_hi  (w_ld_hi),
        .i_load_val (w_new),
        .o_count    (w_mcycle)
    );
endmodule
